// File: rtl/niosii_system_onchip_memory_loader.sv
// Byte-stream loader: packs bytes little-endian into 32-bit words and writes them
// to consecutive word addresses of the on-chip memory, flagging address overflow.
module niosii_system_onchip_memory_loader #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 6500
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] word_count
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_PACK, S_WRITE, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_byte_idx;
    logic [31:0]       r_pack;
    logic [3:0]        r_mask;
    logic              r_last;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_address;
    logic [31:0]       r_mem_writedata;
    logic [3:0]        r_mem_byteenable;
    logic              r_error;
    logic [ADDR_W-1:0] r_word_count;

    logic              w_accept;
    logic              w_word_end;
    logic              w_start_bad;
    logic              w_wrap;
    logic [ADDR_W:0]   w_addr_inc;
    logic [31:0]       w_lane_data;
    logic [3:0]        w_lane_mask;

    assign in_ready       = (r_state == S_PACK) || (r_state == S_DRAIN);
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);
    assign mem_clken      = 1'b1;
    assign mem_write      = r_mem_write;
    assign mem_chipselect = r_mem_write;
    assign mem_address    = r_mem_address;
    assign mem_writedata  = r_mem_writedata;
    assign mem_byteenable = r_mem_byteenable;
    assign error          = r_error;
    assign word_count     = r_word_count;

    assign w_accept    = in_valid & in_ready;
    assign w_word_end  = w_accept && (r_state == S_PACK) && ((r_byte_idx == 2'd3) || in_last);
    assign w_start_bad = ({1'b0, start_addr} >= LP_DEPTH);
    assign w_addr_inc  = {1'b0, r_addr} + (ADDR_W+1)'(1);
    assign w_wrap      = (w_addr_inc == LP_DEPTH);
    assign w_lane_data = {24'd0, in_data} << {r_byte_idx, 3'b000};
    assign w_lane_mask = 4'b0001 << r_byte_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_start_bad ? S_DRAIN : S_PACK;
            S_PACK:  if (w_word_end) w_next = S_WRITE;
            S_WRITE: w_next = r_last ? S_DONE : (w_wrap ? S_DRAIN : S_PACK);
            S_DRAIN: if (w_accept && in_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Memory port is loaded on the edge that completes a word so the write strobe
    // comes straight from a flop during the WRITE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr           <= '0;
            r_byte_idx       <= '0;
            r_pack           <= '0;
            r_mask           <= '0;
            r_last           <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_address    <= '0;
            r_mem_writedata  <= '0;
            r_mem_byteenable <= '0;
            r_error          <= 1'b0;
            r_word_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr       <= start_addr;
                        r_word_count <= '0;
                        r_error      <= w_start_bad;
                        r_byte_idx   <= '0;
                        r_pack       <= '0;
                        r_mask       <= '0;
                        r_last       <= 1'b0;
                    end
                end
                S_PACK: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (w_word_end) begin
                            r_mem_write      <= 1'b1;
                            r_mem_address    <= r_addr;
                            r_mem_writedata  <= r_pack | w_lane_data;
                            r_mem_byteenable <= r_mask | w_lane_mask;
                            r_last           <= in_last;
                            r_pack           <= '0;
                            r_mask           <= '0;
                        end else begin
                            r_pack <= r_pack | w_lane_data;
                            r_mask <= r_mask | w_lane_mask;
                        end
                    end
                end
                S_WRITE: begin
                    r_mem_write  <= 1'b0;
                    r_addr       <= r_addr + ADDR_W'(1);
                    r_word_count <= r_word_count + ADDR_W'(1);
                    if (!r_last && w_wrap) r_error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_niosii_system_onchip_memory_loader.sv
// Bench for the memory loader: directed and random transfers compared against a
// word-level model of the expected writes, word count and error flag.
module tb_niosii_system_onchip_memory_loader;

    localparam int AW  = 13;
    localparam int DEP = 6500;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect;
    logic          mem_write;
    logic [31:0]   mem_writedata;
    logic          mem_clken;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] word_count;

    niosii_system_onchip_memory_loader #(.ADDR_W(AW), .DEPTH(DEP)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    be;
    } wr_t;

    wr_t got_q[$];
    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe the memory port on the falling edge
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("port/cs_eq_write", {31'd0, mem_chipselect}, {31'd0, mem_write});
            check("port/clken", {31'd0, mem_clken}, 32'd1);
            if (mem_write === 1'b1) begin
                got_q.push_back('{a: mem_address, d: mem_writedata, be: mem_byteenable});
                check("port/ready_low_in_write", {31'd0, in_ready}, 32'd0);
            end
        end
    end

    // Each word w covers bytes 4w..4w+3 at address a+w; any word beyond DEPTH-1 is an overflow.
    task automatic model(input int a, input logic [7:0] b[$], output int wc, output logic err);
        wr_t e;
        exp_q.delete();
        wc  = 0;
        err = (a >= DEP);
        for (int w = 0; w * 4 < b.size(); w++) begin
            if (a + w >= DEP) begin
                err = 1'b1;
                break;
            end
            e.a  = AW'(a + w);
            e.d  = '0;
            e.be = '0;
            for (int l = 0; l < 4 && (w * 4 + l) < b.size(); l++) begin
                e.d[8*l +: 8] = b[w*4+l];
                e.be[l]       = 1'b1;
            end
            exp_q.push_back(e);
            wc++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "/in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "/mem_write"}, {31'd0, mem_write}, 32'd0);
        check({tag, "/mem_cs"}, {31'd0, mem_chipselect}, 32'd0);
        check({tag, "/mem_addr"}, 32'(mem_address), 32'd0);
        check({tag, "/mem_be"}, 32'(mem_byteenable), 32'd0);
        check({tag, "/mem_data"}, mem_writedata, 32'd0);
        check({tag, "/clken"}, {31'd0, mem_clken}, 32'd1);
        check({tag, "/busy"}, {31'd0, busy}, 32'd0);
        check({tag, "/done"}, {31'd0, done}, 32'd0);
        check({tag, "/error"}, {31'd0, error}, 32'd0);
        check({tag, "/wc"}, 32'(word_count), 32'd0);
    endtask

    task automatic transfer(input string tag, input int a, input logic [7:0] b[$],
                            input bit gapped, input bit extra_start);
        int   wc;
        logic err;
        int   idx;
        int   budget;
        bit   acc;
        bit   seen;
        bit   fired;
        model(a, b, wc, err);
        got_q.delete();
        idx   = 0;
        fired = 1'b0;
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = AW'(a);
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "/busy_c1"}, {31'd0, busy}, 32'd1);
        check({tag, "/ready_c1"}, {31'd0, in_ready}, 32'd1);
        check({tag, "/err_c1"}, {31'd0, error}, (a >= DEP) ? 32'd1 : 32'd0);
        budget = 0;
        while (idx < b.size() && budget < 400) begin
            in_valid = gapped ? (budget % 2 == 0) : 1'b1;
            in_data  = b[idx];
            in_last  = (idx == b.size() - 1);
            if (extra_start && !fired && idx == 2) begin
                start      = 1'b1;
                start_addr = AW'(a + 100);
                fired      = 1'b1;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) idx++;
            budget++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, "/bytes_accepted"}, 32'(idx), 32'(b.size()));
        seen   = 1'b0;
        budget = 0;
        while (!seen && budget < 20) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                budget++;
            end
        end
        check({tag, "/done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "/done_latency"}, 32'(budget), err ? 32'd0 : 32'd1);
        check({tag, "/busy_in_done"}, {31'd0, busy}, 32'd1);
        check({tag, "/word_count"}, 32'(word_count), 32'(wc));
        check({tag, "/error"}, {31'd0, error}, {31'd0, err});
        @(posedge clk); #1;
        check({tag, "/done_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, "/busy_after"}, {31'd0, busy}, 32'd0);
        check({tag, "/error_sticky"}, {31'd0, error}, {31'd0, err});
        check({tag, "/n_writes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "/wr_addr"}, 32'(got_q[i].a), 32'(exp_q[i].a));
            check({tag, "/wr_data"}, got_q[i].d, exp_q[i].d);
            check({tag, "/wr_be"}, 32'(got_q[i].be), 32'(exp_q[i].be));
        end
    endtask

    logic [7:0] bq[$];
    int         ra;
    int         rl;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        in_data    = '0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        bq = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        transfer("full_words", 'h010, bq, 1'b0, 1'b0);

        bq = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        transfer("partial_tail", 0, bq, 1'b0, 1'b0);

        bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        transfer("overflow", 6499, bq, 1'b0, 1'b0);

        bq = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        transfer("gapped", 'h010, bq, 1'b1, 1'b1);

        // Reset arriving two bytes into a word
        got_q.delete();
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = AW'('h20);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        @(posedge clk); #1;
        in_data = 8'hA5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check_reset_vals("reset_mid");
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_mid/no_write", 32'(got_q.size()), 32'd0);
        reset = 1'b0;
        bq = {8'hC1, 8'hC2, 8'hC3, 8'hC4};
        transfer("after_reset", 5, bq, 1'b0, 1'b0);

        bq = {8'h9A, 8'h9B, 8'h9C};
        transfer("bad_start", 6500, bq, 1'b0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            ra = ($urandom_range(0, 1) == 0) ? (DEP - 3 + int'($urandom_range(0, 4)))
                                             : int'($urandom_range(0, DEP - 1));
            rl = int'($urandom_range(1, 13));
            bq.delete();
            for (int i = 0; i < rl; i++) bq.push_back(8'($urandom));
            transfer("random", ra, bq, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/niosii_system_onchip_memory_loader.md
# niosII_system_onchip_memory_loader

Byte-stream-to-memory loader that sits directly upstream of the on-chip memory's Avalon-MM slave port. It accepts a byte stream (UART/SPI receiver output) over a valid/ready handshake. It packs the bytes little-endian into 32-bit words and issues single-cycle writes at incrementing word addresses, with byte enables for a partial final word. The Nios II starts each transfer, supplying the start address, and reads back status.

## Interface
- ADDR_W, 13, word-address width of the target memory
- DEPTH, 6500, number of valid words in the target memory; valid addresses are 0..DEPTH-1
- clk  input  1  system clock; all logic rises on posedge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a transfer; ignored while busy=1
- start_addr  input  ADDR_W  first word address, sampled on start
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_last  input  1  marks final byte of the transfer; qualified by in_valid
- in_ready  output  1  loader accepts a byte this cycle
- mem_address  output  ADDR_W  word address to memory
- mem_byteenable  output  4  lane enables; bit i enables writedata[8i+7:8i]
- mem_chipselect  output  1  asserted only together with mem_write
- mem_write  output  1  one-cycle write strobe
- mem_writedata  output  32  packed word
- mem_clken  output  1  constant 1
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse at transfer end
- error  output  1  sticky address overflow; cleared by the next accepted start
- word_count  output  ADDR_W  writes issued in the current or last transfer

## Operation
- Reset values: in_ready=0, mem_write=0, mem_chipselect=0, mem_address=0, mem_byteenable=0, mem_writedata=0, busy=0, done=0, error=0, word_count=0, FSM=IDLE, byte_idx=0. mem_clken=1 at all times.
- A byte is accepted when in_valid & in_ready.
- **IDLE**: in_ready=0.
  - On start: load addr←start_addr, word_count←0, error←0, byte_idx←0, clear the packing register, then go to PACK.
  - If start_addr ≥ DEPTH, also set error=1 and go to DRAIN instead of PACK.
- **PACK**: in_ready=1.
  - An accepted byte goes to lane byte_idx and sets bit byte_idx of the pending enable mask; byte_idx increments mod 4.
  - If byte_idx==3 or in_last, go to WRITE.
- **WRITE**: lasts one cycle, with in_ready=0.
  - The memory outputs are registered: mem_write=mem_chipselect=1, mem_address=addr, mem_writedata=packed word (unused lanes 0), mem_byteenable=mask.
  - Then addr+1, word_count+1, mask and packing register cleared.
  - Next state is DONE if the word held in_last. Otherwise it is PACK, or DRAIN with error=1 if addr+1 == DEPTH.
- **DRAIN**: in_ready=1; bytes are accepted and discarded, and no writes are issued. in_last goes to DONE.
- **DONE**: lasts one cycle. done=1, busy falls at the end of the cycle, then go to IDLE.
- busy=1 in every state except IDLE.
- There is no waitrequest; the memory accepts every write. Address never wraps.
- A start pulse while busy is ignored, with no effect on state or outputs.
- An in_last on a byte that completes a full word is handled exactly like a full word.
- Reset mid-transfer discards the partial word and returns to reset values immediately. No write is issued after reset asserts.

## Timing
- start at cycle 0 → busy=1 and in_ready=1 from cycle 1.
- Fourth byte (or in_last) accepted at cycle n → mem_write=1 at n+1, in_ready=0 at n+1, in_ready=1 again at n+2.
- Sustained throughput is 4 bytes per 5 cycles.
- Final write at cycle m → done=1 at m+1, busy=0 from m+2.
- Drain with in_last at cycle k → done=1 at k+1.
- Memory outputs are driven only from registers; nothing passes combinationally from input to memory port.
- in_ready depends only on FSM state, never on in_valid.

## Test plan
- Full words:
  - Stimulus: start_addr=0x010, then bytes 0x11..0x88 back-to-back, last on 0x88.
  - Required response: write @0x010 data 0x44332211 be 0xF, then write @0x011 data 0x88776655 be 0xF. done pulse, word_count=2, error=0.
- Partial tail:
  - Stimulus: start_addr=0, then 5 bytes 0xAA,0xBB,0xCC,0xDD,0xEE, last on 0xEE.
  - Required response: write @0 data 0xDDCCBBAA be 0xF, then write @1 data 0x000000EE be 0x1. word_count=2.
- Overflow:
  - Stimulus: start_addr=6499, then 8 bytes.
  - Required response: a single write @6499 with be 0xF, error=1, and the 4 remaining bytes accepted with no write. done after last; word_count=1.
- Gapped input:
  - Stimulus: the full-words case with in_valid toggling every cycle, plus a start pulse mid-transfer.
  - Required response: identical writes and data; the second start is ignored.
- Reset mid-word:
  - Stimulus: assert reset after 2 of 4 bytes.
  - Required response: no write occurs; all outputs return to reset values asynchronously. A following transfer from start_addr=5 writes @5 correctly.
- Bad start address:
  - Stimulus: start_addr=6500, then 3 bytes, last on the third.
  - Required response: error=1 from cycle 1, no writes, done after the last byte, word_count=0.
